host_token_sender: RTL and testbench

//  Host-side transmitter for token and handshake packets: IN/OUT/SETUP/SOF

---
 rtl/host_token_sender.sv | 184 ++++++++++++++++++
 tb/tb_host_token_sender.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_token_sender.sv
// Host-side token / handshake packet transmitter.
// Sends IN/OUT/SETUP/SOF tokens (PID, two field bytes carrying CRC5) and
// ACK/NAK/STALL handshakes (PID only) to the HC Tx port arbiter. Each packet
// ends with a STOP write.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   sendPacketWEn/PID           request strobe and PID from the controller
//   tgtAddress/tgtEndP          token address / endpoint
//   frameNum                    SOF frame number
//   sendPacketRdy               idle, request may be issued
//   pidError                    1-cycle pulse for a PID that cannot be sent
//   HCTxPortReq/Gnt             arbiter request / grant
//   HCTxPortRdy/WEn/Data/Cntl   Tx port write interface
module host_token_sender #(
    parameter logic [7:0] CNTL_PKT_START = 8'h00,
    parameter logic [7:0] CNTL_PKT_DATA  = 8'h01,
    parameter logic [7:0] CNTL_PKT_STOP  = 8'h02
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sendPacketWEn,
    input  logic [3:0]  sendPacketPID,
    input  logic [6:0]  tgtAddress,
    input  logic [3:0]  tgtEndP,
    input  logic [10:0] frameNum,
    output logic        sendPacketRdy,
    output logic        pidError,
    output logic        HCTxPortReq,
    input  logic        HCTxPortGnt,
    input  logic        HCTxPortRdy,
    output logic        HCTxPortWEn,
    output logic [7:0]  HCTxPortData,
    output logic [7:0]  HCTxPortCntl
);

    localparam int unsigned FLD_W = 11;
    localparam int unsigned CRC_W = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_PID,
        S_FLD1,
        S_FLD2,
        S_STOP
    } state_t;

    state_t             state, state_d;
    logic [3:0]         pid_q, pid_d;
    logic [FLD_W-1:0]   fld_q, fld_d;
    logic               tok_q, tok_d;
    logic               rdy_d, err_d, req_d, wen_d;
    logic [7:0]         data_d, cntl_d;
    logic [CRC_W-1:0]   crc;
    logic [7:0]         b2;

    function automatic logic is_token(input logic [3:0] p);
        return (p == 4'h1) || (p == 4'h9) || (p == 4'h5) || (p == 4'hD);
    endfunction

    function automatic logic is_handshake(input logic [3:0] p);
        return (p == 4'h2) || (p == 4'hA) || (p == 4'hE);
    endfunction

    // CRC5 (x^5+x^2+1), seed all ones, LSB of the field first, inverted result
    function automatic logic [CRC_W-1:0] crc5(input logic [FLD_W-1:0] f);
        logic [CRC_W-1:0] c;
        logic             fb;
        c = 5'h1F;
        for (int i = 0; i < int'(FLD_W); i++) begin
            fb = c[4] ^ f[i];
            c  = {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
        end
        return ~c;
    endfunction

    assign crc = crc5(fld_q);
    // CRC goes out MSB first on the wire, so it is bit-reversed into the byte
    assign b2  = {crc[0], crc[1], crc[2], crc[3], crc[4], fld_q[10:8]};

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            pid_q         <= 4'h0;
            fld_q         <= '0;
            tok_q         <= 1'b0;
            sendPacketRdy <= 1'b1;
            pidError      <= 1'b0;
            HCTxPortReq   <= 1'b0;
            HCTxPortWEn   <= 1'b0;
            HCTxPortData  <= 8'h00;
            HCTxPortCntl  <= 8'h00;
        end else begin
            state         <= state_d;
            pid_q         <= pid_d;
            fld_q         <= fld_d;
            tok_q         <= tok_d;
            sendPacketRdy <= rdy_d;
            pidError      <= err_d;
            HCTxPortReq   <= req_d;
            HCTxPortWEn   <= wen_d;
            HCTxPortData  <= data_d;
            HCTxPortCntl  <= cntl_d;
        end
    end

    // Next-state and next-output logic. A write is only issued when the
    // previous cycle had no strobe, so WEn never stays high two cycles.
    always_comb begin
        state_d = state;
        pid_d   = pid_q;
        fld_d   = fld_q;
        tok_d   = tok_q;
        rdy_d   = sendPacketRdy;
        err_d   = 1'b0;
        req_d   = HCTxPortReq;
        wen_d   = 1'b0;
        data_d  = HCTxPortData;
        cntl_d  = HCTxPortCntl;
        unique case (state)
            S_IDLE: begin
                if (sendPacketWEn && sendPacketRdy) begin
                    if (is_token(sendPacketPID) || is_handshake(sendPacketPID)) begin
                        pid_d   = sendPacketPID;
                        tok_d   = is_token(sendPacketPID);
                        fld_d   = (sendPacketPID == 4'h5) ? frameNum
                                                          : {tgtEndP, tgtAddress};
                        rdy_d   = 1'b0;
                        req_d   = 1'b1;
                        state_d = S_REQ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (HCTxPortGnt) begin
                    state_d = S_PID;
                end
            end
            S_PID: begin
                if (HCTxPortRdy && !HCTxPortWEn) begin
                    wen_d   = 1'b1;
                    data_d  = {~pid_q, pid_q};
                    cntl_d  = CNTL_PKT_START;
                    state_d = tok_q ? S_FLD1 : S_STOP;
                end
            end
            S_FLD1: begin
                if (HCTxPortRdy && !HCTxPortWEn) begin
                    wen_d   = 1'b1;
                    data_d  = fld_q[7:0];
                    cntl_d  = CNTL_PKT_DATA;
                    state_d = S_FLD2;
                end
            end
            S_FLD2: begin
                if (HCTxPortRdy && !HCTxPortWEn) begin
                    wen_d   = 1'b1;
                    data_d  = b2;
                    cntl_d  = CNTL_PKT_DATA;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (HCTxPortRdy && !HCTxPortWEn) begin
                    wen_d   = 1'b1;
                    data_d  = 8'h00;
                    cntl_d  = CNTL_PKT_STOP;
                    req_d   = 1'b0;
                    rdy_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
                rdy_d   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_host_token_sender.sv
// Directed testbench for host_token_sender.
module tb_host_token_sender;

    localparam logic [7:0] C_START = 8'h00;
    localparam logic [7:0] C_DATA  = 8'h01;
    localparam logic [7:0] C_STOP  = 8'h02;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sendPacketWEn = 1'b0;
    logic [3:0]  sendPacketPID = 4'h0;
    logic [6:0]  tgtAddress = 7'h00;
    logic [3:0]  tgtEndP = 4'h0;
    logic [10:0] frameNum = 11'h000;
    logic        sendPacketRdy;
    logic        pidError;
    logic        HCTxPortReq;
    logic        HCTxPortGnt = 1'b1;
    logic        HCTxPortRdy = 1'b1;
    logic        HCTxPortWEn;
    logic [7:0]  HCTxPortData;
    logic [7:0]  HCTxPortCntl;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] wr_data[$];
    logic [7:0] wr_cntl[$];
    int         wr_cyc[$];

    always #5 clk = ~clk;

    host_token_sender dut (
        .clk           (clk),
        .rst           (rst),
        .sendPacketWEn (sendPacketWEn),
        .sendPacketPID (sendPacketPID),
        .tgtAddress    (tgtAddress),
        .tgtEndP       (tgtEndP),
        .frameNum      (frameNum),
        .sendPacketRdy (sendPacketRdy),
        .pidError      (pidError),
        .HCTxPortReq   (HCTxPortReq),
        .HCTxPortGnt   (HCTxPortGnt),
        .HCTxPortRdy   (HCTxPortRdy),
        .HCTxPortWEn   (HCTxPortWEn),
        .HCTxPortData  (HCTxPortData),
        .HCTxPortCntl  (HCTxPortCntl)
    );

    // Reflected-form CRC5: returns the five bits that occupy byte2[7:3]
    function automatic logic [4:0] ref_crc_hi(input logic [10:0] f);
        logic [4:0] r;
        r = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            if (r[0] ^ f[i]) r = (r >> 1) ^ 5'h14;
            else             r = r >> 1;
        end
        return ~r;
    endfunction

    // Write monitor: logs every strobe and checks strobe qualification
    initial begin
        logic rdy_at_edge;
        logic wen_prev;
        wen_prev = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            rdy_at_edge = HCTxPortRdy;
            #1;
            if (!rst && HCTxPortWEn) begin
                wr_data.push_back(HCTxPortData);
                wr_cntl.push_back(HCTxPortCntl);
                wr_cyc.push_back(cyc);
                checks++;
                if (!rdy_at_edge) begin
                    errors++;
                    $display("FAIL wen_rdy: WEn issued with HCTxPortRdy=%0b, required 1", rdy_at_edge);
                end
                checks++;
                if (wen_prev) begin
                    errors++;
                    $display("FAIL wen_b2b: WEn high on consecutive cycles, required isolated pulse");
                end
                if (HCTxPortCntl == C_STOP) begin
                    checks++;
                    if (HCTxPortReq !== 1'b0 || sendPacketRdy !== 1'b1) begin
                        errors++;
                        $display("FAIL stop_exit: Req=%0b Rdy=%0b on STOP write, required Req=0 Rdy=1",
                                 HCTxPortReq, sendPacketRdy);
                    end
                end
            end
            wen_prev = rst ? 1'b0 : HCTxPortWEn;
        end
    end

    task automatic clear_log();
        wr_data.delete();
        wr_cntl.delete();
        wr_cyc.delete();
    endtask

    // Issue a request (one-cycle WEn); returns the cycle count at drive time
    task automatic request(input string nm, input logic [3:0] pid, input logic [6:0] addr,
                           input logic [3:0] endp, input logic [10:0] frame, output int drv_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while (!sendPacketRdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            errors++;
            $display("FAIL %s_rdy_timeout: sendPacketRdy=%0b, required 1", nm, sendPacketRdy);
        end
        sendPacketPID = pid;
        tgtAddress    = addr;
        tgtEndP       = endp;
        frameNum      = frame;
        sendPacketWEn = 1'b1;
        drv_cyc       = cyc;
        @(negedge clk);
        sendPacketWEn = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!(sendPacketRdy && !HCTxPortReq) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL %s_done_timeout: Rdy=%0b Req=%0b, required Rdy=1 Req=0",
                     nm, sendPacketRdy, HCTxPortReq);
        end
    endtask

    task automatic check_pkt(input string nm, input bit tok, input logic [7:0] b0,
                             input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] ed[4];
        logic [7:0] ec[4];
        int n;
        if (tok) begin
            n = 4;
            ed[0] = b0; ec[0] = C_START;
            ed[1] = b1; ec[1] = C_DATA;
            ed[2] = b2; ec[2] = C_DATA;
            ed[3] = 8'h00; ec[3] = C_STOP;
        end else begin
            n = 2;
            ed[0] = b0; ec[0] = C_START;
            ed[1] = 8'h00; ec[1] = C_STOP;
            ed[2] = 8'h00; ec[2] = 8'h00;
            ed[3] = 8'h00; ec[3] = 8'h00;
        end
        checks++;
        if (wr_data.size() != n) begin
            errors++;
            $display("FAIL %s_count: %0d writes, required %0d", nm, wr_data.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (wr_data[i] !== ed[i] || wr_cntl[i] !== ec[i]) begin
                    errors++;
                    $display("FAIL %s_byte%0d: got %02h/%02h, required %02h/%02h",
                             nm, i, wr_data[i], wr_cntl[i], ed[i], ec[i]);
                end
            end
        end
        clear_log();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (sendPacketRdy !== 1'b1 || pidError !== 1'b0 || HCTxPortReq !== 1'b0 ||
            HCTxPortWEn !== 1'b0 || HCTxPortData !== 8'h00 || HCTxPortCntl !== 8'h00) begin
            errors++;
            $display("FAIL reset_vals: rdy=%0b err=%0b req=%0b wen=%0b data=%02h cntl=%02h, required 1 0 0 0 00 00",
                     sendPacketRdy, pidError, HCTxPortReq, HCTxPortWEn, HCTxPortData, HCTxPortCntl);
        end
        rst = 1'b0;
        clear_log();
    endtask

    task automatic test_tokens();
        int d;
        request("setup", 4'hD, 7'h00, 4'h0, 11'h000, d);
        checks++;
        if (sendPacketRdy !== 1'b0 || HCTxPortReq !== 1'b1) begin
            errors++;
            $display("FAIL setup_busy: Rdy=%0b Req=%0b, required 0 1", sendPacketRdy, HCTxPortReq);
        end
        wait_done("setup");
        checks++;
        if (wr_cyc.size() == 0 || wr_cyc[0] - d != 3) begin
            errors++;
            $display("FAIL setup_latency: first write %0d cycles after accept, required 3",
                     (wr_cyc.size() == 0) ? -1 : wr_cyc[0] - d);
        end
        check_pkt("setup", 1'b1, 8'h2D, 8'h00, 8'h10);
        request("sof", 4'h5, 7'h7F, 4'hF, 11'h000, d);
        wait_done("sof");
        check_pkt("sof", 1'b1, 8'hA5, 8'h00, 8'h10);
        request("in", 4'h9, 7'h00, 4'h0, 11'h7FF, d);
        wait_done("in");
        check_pkt("in", 1'b1, 8'h69, 8'h00, 8'h10);
    endtask

    task automatic test_handshake();
        int d;
        request("nak", 4'hA, 7'h00, 4'h0, 11'h000, d);
        wait_done("nak");
        check_pkt("nak", 1'b0, 8'h5A, 8'h00, 8'h00);
        request("ack", 4'h2, 7'h12, 4'h3, 11'h000, d);
        wait_done("ack");
        check_pkt("ack", 1'b0, 8'hD2, 8'h00, 8'h00);
        request("stall", 4'hE, 7'h00, 4'h0, 11'h000, d);
        wait_done("stall");
        check_pkt("stall", 1'b0, 8'h1E, 8'h00, 8'h00);
    endtask

    task automatic test_pid_error();
        int d;
        request("piderr", 4'h3, 7'h00, 4'h0, 11'h000, d);
        checks++;
        if (pidError !== 1'b1 || HCTxPortReq !== 1'b0 || sendPacketRdy !== 1'b1) begin
            errors++;
            $display("FAIL piderr_pulse: err=%0b req=%0b rdy=%0b, required 1 0 1",
                     pidError, HCTxPortReq, sendPacketRdy);
        end
        @(negedge clk);
        checks++;
        if (pidError !== 1'b0 || HCTxPortReq !== 1'b0) begin
            errors++;
            $display("FAIL piderr_end: err=%0b req=%0b, required 0 0", pidError, HCTxPortReq);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (wr_data.size() != 0) begin
            errors++;
            $display("FAIL piderr_nowrite: %0d writes, required 0", wr_data.size());
        end
        clear_log();
    endtask

    task automatic test_flow_control();
        int d;
        int n;
        HCTxPortGnt = 1'b0;
        request("flow", 4'h1, 7'h15, 4'hE, 11'h000, d);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                sendPacketPID = 4'hA;
                tgtAddress    = 7'h7F;
                sendPacketWEn = 1'b1;
            end else begin
                sendPacketWEn = 1'b0;
            end
            @(negedge clk);
        end
        sendPacketWEn = 1'b0;
        checks++;
        if (HCTxPortReq !== 1'b1 || wr_data.size() != 0) begin
            errors++;
            $display("FAIL flow_wait_gnt: req=%0b writes=%0d, required 1 0", HCTxPortReq, wr_data.size());
        end
        HCTxPortGnt = 1'b1;
        n = 0;
        while (!(sendPacketRdy && !HCTxPortReq) && n < 100) begin
            HCTxPortRdy = ~HCTxPortRdy;
            @(negedge clk);
            n++;
        end
        HCTxPortRdy = 1'b1;
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL flow_timeout: Rdy=%0b Req=%0b, required 1 0", sendPacketRdy, HCTxPortReq);
        end
        // OUT addr 0x15 endp 0xE: F = 0x715
        check_pkt("flow", 1'b1, 8'hE1, 8'h15, {ref_crc_hi(11'h715), 3'h7});
    endtask

    task automatic test_reset_mid_packet();
        int d;
        int n;
        request("abort", 4'hD, 7'h00, 4'h0, 11'h000, d);
        n = 0;
        while (wr_data.size() < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (n >= 50 || HCTxPortReq !== 1'b0 || HCTxPortWEn !== 1'b0 || sendPacketRdy !== 1'b1) begin
            errors++;
            $display("FAIL abort_reset: req=%0b wen=%0b rdy=%0b writes=%0d, required 0 0 1 2",
                     HCTxPortReq, HCTxPortWEn, sendPacketRdy, wr_data.size());
        end
        @(negedge clk);
        rst = 1'b0;
        clear_log();
        request("after_abort", 4'hD, 7'h00, 4'h0, 11'h000, d);
        wait_done("after_abort");
        check_pkt("after_abort", 1'b1, 8'h2D, 8'h00, 8'h10);
    endtask

    task automatic test_random_crc();
        int d;
        logic [6:0]  a;
        logic [3:0]  e;
        logic [10:0] f;
        logic [10:0] fr;
        for (int i = 0; i < 4; i++) begin
            a  = 7'($urandom_range(0, 127));
            e  = 4'($urandom_range(0, 15));
            fr = 11'($urandom_range(0, 2047));
            f  = {e, a};
            request("rnd_out", 4'h1, a, e, fr, d);
            wait_done("rnd_out");
            check_pkt("rnd_out", 1'b1, 8'hE1, f[7:0], {ref_crc_hi(f), f[10:8]});
            request("rnd_sof", 4'h5, a, e, fr, d);
            wait_done("rnd_sof");
            check_pkt("rnd_sof", 1'b1, 8'hA5, fr[7:0], {ref_crc_hi(fr), fr[10:8]});
        end
    endtask

    initial begin
        test_reset();
        test_tokens();
        test_handshake();
        test_pid_error();
        test_flow_control();
        test_reset_mid_packet();
        test_random_crc();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
